vend_sequencer: RTL and testbench

Transaction controller for the Basys 3 vending machine. Accepts coin pulses and product selections, keeps the credit balance, and drives the dispense strobe. It also pays out change or refunds one unit at a time. It sits between the board's synchronized input logic (switches/button edges) and the display/LED logic, and uses the scaled tick from the clock prescaler for all human-visible timing.

---
 rtl/vend_pkg.sv | 32 +++
 rtl/vend_tick_timer.sv | 30 +++
 rtl/vend_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_vend_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine transaction controller.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CREDIT,
        DISPENSE,
        CHANGE
    } state_t;

    typedef logic [3:0] credit_t;

    localparam credit_t COIN1_VAL = 4'd1;
    localparam credit_t COIN2_VAL = 4'd2;

    // Prices stay parameters of the top, so they are passed in rather than fixed here.
    function automatic int unsigned price_of(
        input logic [1:0]  sel_id,
        input int unsigned p0,
        input int unsigned p1,
        input int unsigned p2,
        input int unsigned p3
    );
        case (sel_id)
            2'd0:    return p0;
            2'd1:    return p1;
            2'd2:    return p2;
            default: return p3;
        endcase
    endfunction

endpackage

// File: rtl/vend_tick_timer.sv
// Tick-enabled down-counter; done flags the tick that takes the count from 1 to 0.
module vend_tick_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clear,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = tick && (count == WIDTH'(1));

endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction controller: credit keeping, selection, dispense strobe and change payout.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int unsigned PRICE0        = 3,
    parameter int unsigned PRICE1        = 5,
    parameter int unsigned PRICE2        = 7,
    parameter int unsigned PRICE3        = 9,
    parameter int unsigned MAX_CREDIT    = 15,
    parameter int unsigned DISP_TICKS    = 4,
    parameter int unsigned TIMEOUT_TICKS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       coin1,
    input  logic       coin2,
    input  logic       sel_valid,
    input  logic [1:0] sel_id,
    output logic       sel_ready,
    input  logic       cancel,
    output logic [3:0] credit,
    output logic       busy,
    output logic       dispense,
    output logic [1:0] dispense_id,
    output logic       change_pulse,
    output logic       coin_reject,
    output logic       err_price
);

    localparam int unsigned TW = 8;
    localparam logic [TW-1:0] DISP_LOAD    = TW'((DISP_TICKS == 0) ? 1 : DISP_TICKS);
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'((TIMEOUT_TICKS == 0) ? 1 : TIMEOUT_TICKS);
    localparam logic [4:0]    MAX_C        = 5'(MAX_CREDIT);

    state_t        state;
    logic          coin_any;
    credit_t       coin_val;
    logic [4:0]    coin_sum;
    logic          coin_fits;
    int unsigned   sel_price;
    logic          afford;
    logic          t_load;
    logic          t_clear;
    logic [TW-1:0] t_val;
    logic          t_done;

    assign coin_any  = coin1 | coin2;
    assign coin_val  = coin2 ? COIN2_VAL : COIN1_VAL;
    assign coin_sum  = {1'b0, credit} + {1'b0, coin_val};
    assign coin_fits = (coin_sum <= MAX_C);
    assign sel_price = price_of(sel_id, PRICE0, PRICE1, PRICE2, PRICE3);
    assign afford    = ({28'd0, credit} >= sel_price);
    assign sel_ready = (state == IDLE || state == CREDIT) && sel_valid && !coin_any && !cancel;

    // One timer serves three roles: timeout in CREDIT, strobe width in DISPENSE,
    // and one-tick phase pacing in CHANGE (reloaded with 1 each phase).
    always_comb begin
        t_load  = 1'b0;
        t_clear = 1'b0;
        t_val   = TIMEOUT_LOAD;
        case (state)
            IDLE: begin
                if (coin_any) t_load = 1'b1;
                else          t_clear = 1'b1;
            end
            CREDIT: begin
                if (cancel) begin
                    t_load = 1'b1;
                    t_val  = TW'(1);
                end else if (coin_any) begin
                    t_load = 1'b1;
                end else if (sel_ready) begin
                    t_load = 1'b1;
                    if (afford) t_val = DISP_LOAD;
                end else if (t_done) begin
                    t_load = 1'b1;
                    t_val  = TW'(1);
                end
            end
            DISPENSE, CHANGE: begin
                if (t_done) begin
                    t_load = 1'b1;
                    t_val  = TW'(1);
                end
            end
            default: ;
        endcase
    end

    vend_tick_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .load     (t_load),
        .load_val (t_val),
        .clear    (t_clear),
        .done     (t_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            credit       <= '0;
            busy         <= 1'b0;
            dispense     <= 1'b0;
            dispense_id  <= '0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            err_price    <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            err_price   <= 1'b0;
            case (state)
                IDLE: begin
                    if (coin_any) begin
                        if (coin_fits) begin
                            credit <= coin_sum[3:0];
                            state  <= CREDIT;
                        end
                        coin_reject <= (coin1 & coin2) | !coin_fits;
                    end else if (sel_ready) begin
                        err_price <= 1'b1;
                    end
                end
                CREDIT: begin
                    if (cancel) begin
                        state <= CHANGE;
                        busy  <= 1'b1;
                    end else if (coin_any) begin
                        if (coin_fits) credit <= coin_sum[3:0];
                        coin_reject <= (coin1 & coin2) | !coin_fits;
                    end else if (sel_ready) begin
                        if (afford) begin
                            dispense_id <= sel_id;
                            credit      <= credit - sel_price[3:0];
                            dispense    <= 1'b1;
                            busy        <= 1'b1;
                            state       <= DISPENSE;
                        end else begin
                            err_price <= 1'b1;
                        end
                    end else if (t_done) begin
                        state <= CHANGE;
                        busy  <= 1'b1;
                    end
                end
                DISPENSE: begin
                    coin_reject <= coin_any;
                    if (t_done) begin
                        dispense <= 1'b0;
                        if (credit != '0) begin
                            state <= CHANGE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                CHANGE: begin
                    coin_reject <= coin_any;
                    if (credit == '0) begin
                        state        <= IDLE;
                        busy         <= 1'b0;
                        change_pulse <= 1'b0;
                    end else if (t_done) begin
                        if (change_pulse) begin
                            change_pulse <= 1'b0;
                            credit       <= credit - 1'b1;
                            if (credit == 4'd1) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            change_pulse <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed self-checking bench for vend_sequencer with default parameters.
module tb_vend_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       coin1 = 1'b0;
    logic       coin2 = 1'b0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_id = 2'd0;
    logic       sel_ready;
    logic       cancel = 1'b0;
    logic [3:0] credit;
    logic       busy;
    logic       dispense;
    logic [1:0] dispense_id;
    logic       change_pulse;
    logic       coin_reject;
    logic       err_price;

    int n_pass  = 0;
    int n_total = 0;

    vend_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .coin1        (coin1),
        .coin2        (coin2),
        .sel_valid    (sel_valid),
        .sel_id       (sel_id),
        .sel_ready    (sel_ready),
        .cancel       (cancel),
        .credit       (credit),
        .busy         (busy),
        .dispense     (dispense),
        .dispense_id  (dispense_id),
        .change_pulse (change_pulse),
        .coin_reject  (coin_reject),
        .err_price    (err_price)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All stimulus changes and sampling happen on the falling edge.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic put_coin(input logic c1, input logic c2);
        coin1 = c1;
        coin2 = c2;
        @(negedge clk);
        coin1 = 1'b0;
        coin2 = 1'b0;
    endtask

    task automatic select(input logic [1:0] id, output logic rdy);
        sel_valid = 1'b1;
        sel_id    = id;
        #1 rdy = sel_ready;
        @(negedge clk);
        sel_valid = 1'b0;
    endtask

    task automatic pulse_cancel();
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
    endtask

    task automatic count_dispense(output int n);
        n = 0;
        while (dispense && n < 20) begin
            ticks(1);
            n++;
        end
    endtask

    task automatic drain(output int pulses, output int nt);
        pulses = 0;
        nt = 0;
        while (busy && nt < 100) begin
            ticks(1);
            nt++;
            if (change_pulse) pulses++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_total++; if ({credit, busy, dispense, dispense_id, change_pulse, sel_ready, coin_reject, err_price} !== 11'd0)
            $display("FAIL reset_outputs got %b want all zero", {credit, busy, dispense, dispense_id, change_pulse, sel_ready, coin_reject, err_price});
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_purchase_with_change();
        logic rdy;
        int   n, p, nt;
        put_coin(1'b0, 1'b1);
        n_total++; if (credit !== 4'd2) $display("FAIL s1_credit_first got %0d want 2", credit); else n_pass++;
        put_coin(1'b0, 1'b1);
        n_total++; if (credit !== 4'd4) $display("FAIL s1_credit_second got %0d want 4", credit); else n_pass++;
        select(2'd0, rdy);
        n_total++; if (rdy !== 1'b1) $display("FAIL s1_sel_ready got %b want 1", rdy); else n_pass++;
        n_total++; if ({dispense, dispense_id, credit, busy} !== {1'b1, 2'd0, 4'd1, 1'b1})
            $display("FAIL s1_dispense_start got %b want %b", {dispense, dispense_id, credit, busy}, {1'b1, 2'd0, 4'd1, 1'b1});
        else n_pass++;
        count_dispense(n);
        n_total++; if (n !== 4) $display("FAIL s1_dispense_ticks got %0d want 4", n); else n_pass++;
        drain(p, nt);
        n_total++; if (p !== 1 || nt !== 2) $display("FAIL s1_change got pulses %0d ticks %0d want 1 and 2", p, nt); else n_pass++;
        n_total++; if (credit !== 4'd0 || busy !== 1'b0) $display("FAIL s1_idle got credit %0d busy %b want 0 0", credit, busy); else n_pass++;
    endtask

    task automatic test_insufficient_credit();
        logic rdy;
        int   n, p, nt;
        repeat (3) put_coin(1'b1, 1'b0);
        n_total++; if (credit !== 4'd3) $display("FAIL s2_credit3 got %0d want 3", credit); else n_pass++;
        select(2'd1, rdy);
        n_total++; if (rdy !== 1'b1 || err_price !== 1'b1 || credit !== 4'd3 || busy !== 1'b0)
            $display("FAIL s2_err_price got rdy %b err %b credit %0d busy %b want 1 1 3 0", rdy, err_price, credit, busy);
        else n_pass++;
        @(negedge clk);
        n_total++; if (err_price !== 1'b0) $display("FAIL s2_err_width got %b want 0", err_price); else n_pass++;
        put_coin(1'b0, 1'b1);
        select(2'd1, rdy);
        n_total++; if ({dispense, dispense_id, credit} !== {1'b1, 2'd1, 4'd0})
            $display("FAIL s2_dispense got %b want %b", {dispense, dispense_id, credit}, {1'b1, 2'd1, 4'd0});
        else n_pass++;
        count_dispense(n);
        n_total++; if (n !== 4) $display("FAIL s2_dispense_ticks got %0d want 4", n); else n_pass++;
        drain(p, nt);
        n_total++; if (p !== 0 || busy !== 1'b0 || credit !== 4'd0)
            $display("FAIL s2_no_change got pulses %0d busy %b credit %0d want 0 0 0", p, busy, credit);
        else n_pass++;
    endtask

    task automatic test_coin_overflow();
        int p, nt;
        repeat (7) put_coin(1'b0, 1'b1);
        n_total++; if (credit !== 4'd14) $display("FAIL s3_credit14 got %0d want 14", credit); else n_pass++;
        put_coin(1'b0, 1'b1);
        n_total++; if (coin_reject !== 1'b1 || credit !== 4'd14)
            $display("FAIL s3_overflow got reject %b credit %0d want 1 14", coin_reject, credit);
        else n_pass++;
        @(negedge clk);
        n_total++; if (coin_reject !== 1'b0) $display("FAIL s3_reject_width got %b want 0", coin_reject); else n_pass++;
        pulse_cancel();
        drain(p, nt);
        n_total++; if (p !== 14 || nt !== 28) $display("FAIL s3_refund14 got pulses %0d ticks %0d want 14 28", p, nt); else n_pass++;
        put_coin(1'b1, 1'b1);
        n_total++; if (credit !== 4'd2 || coin_reject !== 1'b1)
            $display("FAIL s3_dual_coin got credit %0d reject %b want 2 1", credit, coin_reject);
        else n_pass++;
        pulse_cancel();
        drain(p, nt);
        n_total++; if (p !== 2 || credit !== 4'd0) $display("FAIL s3_refund2 got pulses %0d credit %0d want 2 0", p, credit); else n_pass++;
    endtask

    task automatic test_cancel_priority();
        int p, nt;
        put_coin(1'b0, 1'b1);
        put_coin(1'b0, 1'b1);
        put_coin(1'b1, 1'b0);
        n_total++; if (credit !== 4'd5) $display("FAIL s4_credit5 got %0d want 5", credit); else n_pass++;
        cancel    = 1'b1;
        sel_valid = 1'b1;
        sel_id    = 2'd0;
        #1;
        n_total++; if (sel_ready !== 1'b0) $display("FAIL s4_sel_ready got %b want 0", sel_ready); else n_pass++;
        @(negedge clk);
        cancel    = 1'b0;
        sel_valid = 1'b0;
        n_total++; if (busy !== 1'b1 || dispense !== 1'b0 || credit !== 4'd5)
            $display("FAIL s4_to_change got busy %b dispense %b credit %0d want 1 0 5", busy, dispense, credit);
        else n_pass++;
        drain(p, nt);
        n_total++; if (p !== 5 || nt !== 10) $display("FAIL s4_refund got pulses %0d ticks %0d want 5 10", p, nt); else n_pass++;
        n_total++; if (busy !== 1'b0 || credit !== 4'd0) $display("FAIL s4_idle got busy %b credit %0d want 0 0", busy, credit); else n_pass++;
    endtask

    task automatic test_timeout();
        int p, nt;
        put_coin(1'b0, 1'b1);
        ticks(19);
        n_total++; if (busy !== 1'b0 || credit !== 4'd2) $display("FAIL s5_before_coin got busy %b credit %0d want 0 2", busy, credit); else n_pass++;
        put_coin(1'b1, 1'b0);
        ticks(19);
        n_total++; if (busy !== 1'b0 || credit !== 4'd3) $display("FAIL s5_restarted got busy %b credit %0d want 0 3", busy, credit); else n_pass++;
        ticks(1);
        n_total++; if (busy !== 1'b1 || change_pulse !== 1'b0) $display("FAIL s5_expired got busy %b pulse %b want 1 0", busy, change_pulse); else n_pass++;
        drain(p, nt);
        n_total++; if (p !== 3 || nt !== 6 || credit !== 4'd0)
            $display("FAIL s5_refund got pulses %0d ticks %0d credit %0d want 3 6 0", p, nt, credit);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        logic rdy;
        int   p, nt;
        put_coin(1'b0, 1'b1);
        put_coin(1'b0, 1'b1);
        select(2'd0, rdy);
        ticks(1);
        n_total++; if (dispense !== 1'b1) $display("FAIL s6_mid_dispense got %b want 1", dispense); else n_pass++;
        reset = 1'b1;
        #1;
        n_total++; if ({dispense, credit, busy} !== 6'd0)
            $display("FAIL s6_async_reset got %b want 000000", {dispense, credit, busy});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        put_coin(1'b1, 1'b0);
        n_total++; if (credit !== 4'd1 || busy !== 1'b0 || coin_reject !== 1'b0)
            $display("FAIL s6_fresh_coin got credit %0d busy %b reject %b want 1 0 0", credit, busy, coin_reject);
        else n_pass++;
        select(2'd0, rdy);
        n_total++; if (err_price !== 1'b1 || credit !== 4'd1) $display("FAIL s6_fresh_err got err %b credit %0d want 1 1", err_price, credit); else n_pass++;
        pulse_cancel();
        drain(p, nt);
        n_total++; if (p !== 1 || busy !== 1'b0) $display("FAIL s6_refund got pulses %0d busy %b want 1 0", p, busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_purchase_with_change();
        test_insufficient_credit();
        test_coin_overflow();
        test_cancel_priority();
        test_timeout();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
